period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter WIDTH, default 16, bit width of all measurement counters and outputs; legal range 4..32.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port clk, input, 1, rising-edge system clock.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port sig_in, input, 1, square wave under measurement (e.g. output of the team's counter divider).
REQ-006 Port period, output, WIDTH, clk cycles between the last two detected rising edges of sig_in.
REQ-007 Port high_time, output, WIDTH, clk cycles from rising edge to falling edge within that period.
REQ-008 Port valid, output, 1, single-cycle strobe: period/high_time/ovf just updated.
REQ-009 Port ovf, output, 1, last reported measurement saturated.

Function
REQ-010 Sampled signal s, previous sample s_d; rise = s & ~s_d, fall = ~s & s_d, evaluated each clk.
REQ-011 FSM states IDLE, MEAS_HIGH, MEAS_LOW; IDLE after reset.
REQ-012 IDLE: on rise -> MEAS_HIGH, cnt <= 1, no valid; fall ignored.
REQ-013 MEAS_HIGH: cnt increments each cycle; on fall -> MEAS_LOW, internal hold <= cnt.
REQ-014 MEAS_LOW: cnt increments; on rise -> MEAS_HIGH, period <= cnt, high_time <= hold, ovf <= sat flag, cnt <= 1, sat flag cleared.
REQ-015 Timing: rise detected at cycles t0, t1 -> period = t1 - t0; high_time = tf - t0 (tf = fall detection cycle).
REQ-016 valid SHALL be high exactly one cycle, the cycle after the t1 rise detection, aligned with the new period/high_time.
REQ-017 cnt SHALL saturate at 2^WIDTH-1 (no wrap) and set a sticky sat flag, cleared only on the reporting rise.
REQ-018 Stuck input (no edges) SHALL produce no valid; outputs hold last values.
REQ-019 First rise after reset only arms; first valid requires two rises.
REQ-020 Minimum pulses: high or low of 1 sampled cycle SHALL be measured (high_time = 1 legal).

Reset
REQ-021 On reset: state IDLE, cnt/hold/sat = 0, s and s_d = 0, period = 0, high_time = 0, valid = 0, ovf = 0.
REQ-022 sig_in high at reset release SHALL be seen as a rise (arms).
REQ-023 Reset mid-measurement SHALL discard partial counts; no valid until two new rises.

Configuration
REQ-024 Macro PERIOD_METER_SYNC_EN defined: sig_in passes a 2-flop synchronizer before s; edge detection latency = 3 cycles from sig_in change.
REQ-025 Macro undefined: s = sig_in registered once; latency = 1 cycle; sig_in must be synchronous to clk.
REQ-026 Measured period/high_time values SHALL be identical in both builds; only latency differs.

Structure
REQ-027 Package period_meter_pkg SHALL hold the state typedef (IDLE, MEAS_HIGH, MEAS_LOW) and constant PERIOD_METER_WIDTH_DEFAULT = 16.
REQ-028 Sub-module period_meter_edge SHALL contain synchronizer (macro-gated), s_d register and rise/fall outputs.

Verification
REQ-029 sig_in 2048 cycles high / 2048 low, WIDTH=16 -> from second rise onward valid every 4096 cycles, period=4096, high_time=2048, ovf=0.
REQ-030 sig_in 3 high / 5 low -> period=8, high_time=3, valid every 8 cycles.
REQ-031 WIDTH=8, sig_in 300 high / 300 low -> period=255, high_time=255, ovf=1; next 10/10 wave -> period=20, high_time=10, ovf=0.
REQ-032 Reset asserted 100 cycles into MEAS_LOW -> outputs 0 immediately, no valid until two rises after release.
REQ-033 sig_in held high 10000 cycles after one rise -> valid stays 0; period/high_time unchanged.
REQ-034 Run REQ-029 with and without PERIOD_METER_SYNC_EN -> same values, valid shifted by exactly 2 cycles.

Source files
------------

// File: rtl/period_meter_pkg.sv
//------------------------------------------------------------------------------
// Module      : period_meter_pkg
// Description : Shared types and constants for the period meter.
//               - pm_state_t : measurement FSM state encoding
//               - PERIOD_METER_WIDTH_DEFAULT : default counter/output width
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package period_meter_pkg;

  // Default bit width of the measurement counters and result outputs.
  localparam int PERIOD_METER_WIDTH_DEFAULT = 16;

  // Narrowest and widest counter widths the meter is built for.
  localparam int PERIOD_METER_WIDTH_MIN = 4;
  localparam int PERIOD_METER_WIDTH_MAX = 32;

  // Measurement FSM:
  //   IDLE      - waiting for the first rising edge (arming)
  //   MEAS_HIGH - counting the high phase of the current period
  //   MEAS_LOW  - counting the low phase; the next rise closes the period
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } pm_state_t;

endpackage : period_meter_pkg

`default_nettype wire

// File: rtl/period_meter_edge.sv
//------------------------------------------------------------------------------
// Module      : period_meter_edge
// Description : Input conditioning and edge detection for the period meter.
//               The sampled signal s is compared against its previous
//               sample s_d to produce single-cycle rise/fall pulses.
//
//               Build option PERIOD_METER_SYNC_EN:
//                 defined   - i_sig passes through a 2-flop synchronizer
//                             before s; edge latency 3 cycles.
//                 undefined - s is i_sig registered once; edge latency
//                             1 cycle (i_sig must be synchronous to clk).
//
// Ports       : clk    - rising-edge system clock
//               reset  - asynchronous active-high reset
//               i_sig  - signal under measurement
//               o_rise - s & ~s_d, high for one cycle per rising edge
//               o_fall - ~s & s_d, high for one cycle per falling edge
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module period_meter_edge
  import period_meter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic w_sig_cond;   // signal feeding the s register
  logic r_s;          // sampled signal
  logic r_s_d;        // previous sample

`ifdef PERIOD_METER_SYNC_EN
  // Two metastability-settling stages ahead of the sampling register.
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_sig};
    end
  end

  assign w_sig_cond = r_sync[1];
`else
  assign w_sig_cond = i_sig;
`endif

  // Both samples clear on reset, so an input already high when reset
  // releases is reported as a rising edge and arms the meter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s   <= 1'b0;
      r_s_d <= 1'b0;
    end else begin
      r_s   <= w_sig_cond;
      r_s_d <= r_s;
    end
  end

  assign o_rise = r_s & ~r_s_d;
  assign o_fall = ~r_s & r_s_d;

endmodule : period_meter_edge

`default_nettype wire

// File: rtl/period_meter.sv
//------------------------------------------------------------------------------
// Module      : period_meter
// Description : Measures the period and high time of a square wave in clk
//               cycles. The first rising edge after reset only arms the
//               meter; every following rising edge reports the period just
//               closed together with its high time and a saturation flag.
//               Counters saturate at 2^WIDTH-1 instead of wrapping.
//
//               Build option PERIOD_METER_SYNC_EN adds a 2-flop input
//               synchronizer (see period_meter_edge). Measured values are the
//               same in both builds; only the report latency moves by 2.
//
// Parameters  : WIDTH     - counter/output width, legal range 4..32
// Ports       : clk       - rising-edge system clock
//               reset     - asynchronous active-high reset
//               sig_in    - square wave under measurement
//               period    - cycles between the last two rising edges
//               high_time - cycles from rising to falling edge in that period
//               valid     - one-cycle strobe: period/high_time/ovf updated
//               ovf       - last reported measurement saturated
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH = PERIOD_METER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] C_CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  //----------------------------------------------------------------------------
  // Edge detection
  //----------------------------------------------------------------------------
  logic w_rise;
  logic w_fall;

  period_meter_edge u_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (sig_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  //----------------------------------------------------------------------------
  // Measurement state
  //----------------------------------------------------------------------------
  pm_state_t        r_state;
  logic [WIDTH-1:0] r_cnt;        // cycles since the opening rising edge
  logic [WIDTH-1:0] r_hold;       // high time captured at the falling edge
  logic             r_sat;        // counter hit its ceiling this period
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;
  logic             r_valid;
  logic             r_ovf;

  logic             w_at_max;
  logic [WIDTH-1:0] w_cnt_next;

  // Saturating increment: once at the ceiling the count stays there and
  // the attempted step is what marks the measurement as saturated.
  assign w_at_max   = (r_cnt == C_CNT_MAX);
  assign w_cnt_next = w_at_max ? r_cnt : (r_cnt + C_CNT_ONE);

  // The count starts at 1 in the cycle after the opening rise, so the
  // value present when an edge is detected equals the distance in cycles
  // from the opening rise to that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_sat       <= 1'b0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          // Only a rise leaves IDLE; a stray fall carries no information.
          if (w_rise) begin
            r_state <= MEAS_HIGH;
            r_cnt   <= C_CNT_ONE;
            r_sat   <= 1'b0;
          end
        end

        MEAS_HIGH: begin
          r_cnt <= w_cnt_next;
          if (w_at_max) begin
            r_sat <= 1'b1;
          end
          if (w_fall) begin
            r_hold  <= r_cnt;
            r_state <= MEAS_LOW;
          end
        end

        MEAS_LOW: begin
          if (w_rise) begin
            // Close the period and immediately open the next one.
            r_period    <= r_cnt;
            r_high_time <= r_hold;
            r_ovf       <= r_sat;
            r_valid     <= 1'b1;
            r_cnt       <= C_CNT_ONE;
            r_sat       <= 1'b0;
            r_state     <= MEAS_HIGH;
          end else begin
            r_cnt <= w_cnt_next;
            if (w_at_max) begin
              r_sat <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign ovf       = r_ovf;

endmodule : period_meter

`default_nettype wire

// File: tb/tb_period_meter.sv
//------------------------------------------------------------------------------
// Module      : tb_period_meter
// Description : Directed self-checking bench for period_meter. Two instances
//               are used: WIDTH=16 for general behaviour and WIDTH=8 for
//               saturation. Expected report latency follows the build
//               option PERIOD_METER_SYNC_EN (1 or 3 cycles of edge delay).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_period_meter;

`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig16 = 1'b0;
  logic        sig8  = 1'b0;

  logic [15:0] per16;
  logic [15:0] hi16;
  logic        val16;
  logic        ovf16;
  logic [7:0]  per8;
  logic [7:0]  hi8;
  logic        val8;
  logic        ovf8;

  period_meter #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig16),
    .period    (per16),
    .high_time (hi16),
    .valid     (val16),
    .ovf       (ovf16)
  );

  period_meter #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig8),
    .period    (per8),
    .high_time (hi8),
    .valid     (val8),
    .ovf       (ovf8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe bookkeeping: how many valids, and on which cycles the last two came.
  int vcnt16 = 0, vcyc16 = 0, vprev16 = 0;
  int vcnt8  = 0;
  always @(negedge clk) begin
    if (val16 === 1'b1) begin
      vprev16 = vcyc16;
      vcyc16  = cyc;
      vcnt16  = vcnt16 + 1;
    end
    if (val8 === 1'b1) begin
      vcnt8 = vcnt8 + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Stimulus helpers: drive a level and advance n cycles, ending #1 after a posedge.
  task automatic hold16(input logic v, input int n);
    sig16 = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold8(input logic v, input int n);
    sig8 = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wave16(input int hi, input int lo, input int n, output int last_rise);
    last_rise = cyc;
    for (int i = 0; i < n; i++) begin
      last_rise = cyc;
      hold16(1'b1, hi);
      hold16(1'b0, lo);
    end
  endtask

  task automatic wave8(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      hold8(1'b1, hi);
      hold8(1'b0, lo);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sig8  = 1'b0;
    hold16(1'b0, 3);
    reset = 1'b0;
  endtask

  //----------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_vec++; if (per16 !== 16'd0) begin n_err++; $display("FAIL reset_period16 got %0d want 0", per16); end
    n_vec++; if (hi16 !== 16'd0) begin n_err++; $display("FAIL reset_high16 got %0d want 0", hi16); end
    n_vec++; if (val16 !== 1'b0) begin n_err++; $display("FAIL reset_valid16 got %b want 0", val16); end
    n_vec++; if (ovf16 !== 1'b0) begin n_err++; $display("FAIL reset_ovf16 got %b want 0", ovf16); end
    n_vec++; if (per8 !== 8'd0 || hi8 !== 8'd0 || val8 !== 1'b0 || ovf8 !== 1'b0) begin
      n_err++; $display("FAIL reset_dut8 got per=%0d hi=%0d val=%b ovf=%b want all 0", per8, hi8, val8, ovf8);
    end
  endtask

  //----------------------------------------------------------------------------
  task automatic test_basic();
    int base, lr;
    do_reset();
    base = vcnt16;
    wave16(3, 5, 5, lr);
    hold16(1'b0, 6);
    n_vec++; if (vcnt16 - base !== 4) begin n_err++; $display("FAIL basic_valid_count got %0d want 4", vcnt16 - base); end
    n_vec++; if (per16 !== 16'd8) begin n_err++; $display("FAIL basic_period got %0d want 8", per16); end
    n_vec++; if (hi16 !== 16'd3) begin n_err++; $display("FAIL basic_high got %0d want 3", hi16); end
    n_vec++; if (ovf16 !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b want 0", ovf16); end
    n_vec++; if (vcyc16 - vprev16 !== 8) begin n_err++; $display("FAIL basic_valid_spacing got %0d want 8", vcyc16 - vprev16); end
    n_vec++; if (vcyc16 - lr !== LAT + 1) begin n_err++; $display("FAIL basic_latency got %0d want %0d", vcyc16 - lr, LAT + 1); end
  endtask

  //----------------------------------------------------------------------------
  task automatic test_min_pulse();
    int tbl_hi [3] = '{1, 1, 4};
    int tbl_lo [3] = '{1, 4, 1};
    int tbl_per[3] = '{2, 5, 5};
    int base, lr;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      base = vcnt16;
      wave16(tbl_hi[k], tbl_lo[k], 3, lr);
      hold16(1'b0, 6);
      n_vec++; if (vcnt16 - base !== 2) begin n_err++; $display("FAIL min_count[%0d] got %0d want 2", k, vcnt16 - base); end
      n_vec++; if (int'(per16) !== tbl_per[k]) begin n_err++; $display("FAIL min_period[%0d] got %0d want %0d", k, per16, tbl_per[k]); end
      n_vec++; if (int'(hi16) !== tbl_hi[k]) begin n_err++; $display("FAIL min_high[%0d] got %0d want %0d", k, hi16, tbl_hi[k]); end
    end
  endtask

  //----------------------------------------------------------------------------
  task automatic test_long();
    int base, lr;
    do_reset();
    base = vcnt16;
    wave16(2048, 2048, 4, lr);
    hold16(1'b0, 6);
    n_vec++; if (vcnt16 - base !== 3) begin n_err++; $display("FAIL long_valid_count got %0d want 3", vcnt16 - base); end
    n_vec++; if (per16 !== 16'd4096) begin n_err++; $display("FAIL long_period got %0d want 4096", per16); end
    n_vec++; if (hi16 !== 16'd2048) begin n_err++; $display("FAIL long_high got %0d want 2048", hi16); end
    n_vec++; if (ovf16 !== 1'b0) begin n_err++; $display("FAIL long_ovf got %b want 0", ovf16); end
    n_vec++; if (vcyc16 - vprev16 !== 4096) begin n_err++; $display("FAIL long_valid_spacing got %0d want 4096", vcyc16 - vprev16); end
    n_vec++; if (vcyc16 - lr !== LAT + 1) begin n_err++; $display("FAIL long_latency got %0d want %0d", vcyc16 - lr, LAT + 1); end
  endtask

  //----------------------------------------------------------------------------
  task automatic test_saturation();
    int base;
    do_reset();
    base = vcnt8;
    wave8(300, 300, 3);
    hold8(1'b0, 6);
    n_vec++; if (vcnt8 - base !== 2) begin n_err++; $display("FAIL sat_valid_count got %0d want 2", vcnt8 - base); end
    n_vec++; if (per8 !== 8'd255) begin n_err++; $display("FAIL sat_period got %0d want 255", per8); end
    n_vec++; if (hi8 !== 8'd255) begin n_err++; $display("FAIL sat_high got %0d want 255", hi8); end
    n_vec++; if (ovf8 !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", ovf8); end
    base = vcnt8;
    wave8(10, 10, 4);
    hold8(1'b0, 6);
    n_vec++; if (vcnt8 - base !== 4) begin n_err++; $display("FAIL sat_recover_count got %0d want 4", vcnt8 - base); end
    n_vec++; if (per8 !== 8'd20) begin n_err++; $display("FAIL sat_recover_period got %0d want 20", per8); end
    n_vec++; if (hi8 !== 8'd10) begin n_err++; $display("FAIL sat_recover_high got %0d want 10", hi8); end
    n_vec++; if (ovf8 !== 1'b0) begin n_err++; $display("FAIL sat_recover_ovf got %b want 0", ovf8); end
  endtask

  //----------------------------------------------------------------------------
  task automatic test_stuck();
    int base, lr, stuck_start;
    do_reset();
    base = vcnt16;
    wave16(3, 5, 3, lr);
    stuck_start = cyc;
    // The rise into the stuck level closes the last 3/5 period; nothing after.
    hold16(1'b1, 10000);
    n_vec++; if (vcnt16 - base !== 3) begin n_err++; $display("FAIL stuck_valid_count got %0d want 3", vcnt16 - base); end
    n_vec++; if (per16 !== 16'd8) begin n_err++; $display("FAIL stuck_period got %0d want 8", per16); end
    n_vec++; if (hi16 !== 16'd3) begin n_err++; $display("FAIL stuck_high got %0d want 3", hi16); end
    n_vec++; if (vcyc16 - stuck_start !== LAT + 1) begin n_err++; $display("FAIL stuck_last_valid got %0d want %0d", vcyc16 - stuck_start, LAT + 1); end
    hold16(1'b0, 4);
  endtask

  //----------------------------------------------------------------------------
  task automatic test_reset_mid();
    int base, lr;
    do_reset();
    wave16(50, 200, 3, lr);
    hold16(1'b1, 50);
    hold16(1'b0, 100);
    reset = 1'b1;
    #1;
    n_vec++; if (per16 !== 16'd0) begin n_err++; $display("FAIL mid_period got %0d want 0", per16); end
    n_vec++; if (hi16 !== 16'd0) begin n_err++; $display("FAIL mid_high got %0d want 0", hi16); end
    n_vec++; if (val16 !== 1'b0 || ovf16 !== 1'b0) begin n_err++; $display("FAIL mid_flags got val=%b ovf=%b want 0 0", val16, ovf16); end
    hold16(1'b0, 2);
    reset = 1'b0;
    base = vcnt16;
    wave16(3, 5, 1, lr);
    n_vec++; if (vcnt16 - base !== 0) begin n_err++; $display("FAIL mid_first_rise_count got %0d want 0", vcnt16 - base); end
    wave16(3, 5, 1, lr);
    hold16(1'b0, 6);
    n_vec++; if (vcnt16 - base !== 1) begin n_err++; $display("FAIL mid_second_rise_count got %0d want 1", vcnt16 - base); end
    n_vec++; if (per16 !== 16'd8 || hi16 !== 16'd3) begin n_err++; $display("FAIL mid_values got per=%0d hi=%0d want 8 3", per16, hi16); end
  endtask

  //----------------------------------------------------------------------------
  task automatic test_release_high();
    int base, lr;
    reset = 1'b1;
    hold16(1'b1, 3);
    reset = 1'b0;
    base = vcnt16;
    // Input already high at release counts as the arming rise.
    hold16(1'b1, 4);
    hold16(1'b0, 6);
    wave16(2, 2, 1, lr);
    hold16(1'b0, 6);
    n_vec++; if (vcnt16 - base !== 1) begin n_err++; $display("FAIL relhigh_count got %0d want 1", vcnt16 - base); end
    n_vec++; if (per16 !== 16'd10) begin n_err++; $display("FAIL relhigh_period got %0d want 10", per16); end
    n_vec++; if (hi16 !== 16'd4) begin n_err++; $display("FAIL relhigh_high got %0d want 4", hi16); end
  endtask

  //----------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_min_pulse();
    test_long();
    test_saturation();
    test_stuck();
    test_reset_mid();
    test_release_high();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_period_meter

`default_nettype wire
